// File: rtl/bram_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
// Holds the FSM state and transfer-type encodings and the default HuBM header.
package bram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK_HI,
        ACK_LO,
        FMT
    } state_e;

    typedef enum logic {
        LOAD,
        SAVE
    } xfer_e;

    localparam int HDR_WORDS = 4;

    localparam logic [15:0] BRAM_HDR [HDR_WORDS] = '{
        16'h5548, 16'h4D42, 16'h8800, 16'h8010
    };

    function automatic logic [15:0] hdr_word(input logic [1:0] idx);
        return BRAM_HDR[idx];
    endfunction

endpackage

// File: rtl/bram_sd_ctrl_if.sv
// hps_io SD sector handshake bundle.
// The master drives the sector address and requests; the slave returns the acknowledge.
interface bram_sd_ctrl_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/bram_sd_ctrl_edge_det.sv
// Single-polarity edge detector against the registered previous sample.
// RST_VAL lets an input that is already high at reset release count as "no edge".
module edge_det #(
    parameter bit RST_VAL = 1'b1,
    parameter bit FALLING = 1'b0
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic prev;

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) prev <= RST_VAL;
        else          prev <= d;
    end

    assign pulse = FALLING ? (prev & ~d) : (d & ~prev);

endmodule

// File: rtl/bram_sd_ctrl.sv
// Backup-RAM save-path sequencer: load/save/autosave/auto-load over hps_io sectors,
// plus the header format sequence on backup RAM port B.
module bram_sd_ctrl
    import bram_pkg::*;
#(
    parameter int SECTORS   = 16,
    parameter int FMT_WORDS = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  bk_ena,
    input  logic                  load_req,
    input  logic                  save_req,
    input  logic                  autosave_en,
    input  logic                  osd_open,
    input  logic                  bram_wr,
    input  logic                  dl_done,
    input  logic                  img_present,
    input  logic                  format_req,
    bram_sd_ctrl_if.master        sd,
    output logic                  busy,
    output logic                  loading,
    output logic                  pending,
    output logic                  fmt_we,
    output logic [1:0]            fmt_addr,
    output logic [15:0]           fmt_data,
    output logic                  done
);

    localparam logic [7:0] LAST_LBA = 8'(SECTORS - 1);
    localparam logic [1:0] LAST_FMT = 2'(FMT_WORDS - 1);

    state_e      state_q, state_d;
    xfer_e       xfer_q, xfer_d;
    logic [7:0]  lba_q, lba_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        busy_d, loading_d, pending_d, done_d;
    logic        fmt_we_d;
    logic [1:0]  fmt_addr_d;
    logic [15:0] fmt_data_d;

    logic load_rise, save_rise, fmt_rise, auto_rise, ack_rise, ack_fall;
    logic trig_load, trig_save, start;

    edge_det u_load (.clk_sys, .reset_n, .d(load_req),   .pulse(load_rise));
    edge_det u_save (.clk_sys, .reset_n, .d(save_req),   .pulse(save_rise));
    edge_det u_fmt  (.clk_sys, .reset_n, .d(format_req), .pulse(fmt_rise));
    edge_det u_auto (.clk_sys, .reset_n, .d(pending & osd_open & autosave_en), .pulse(auto_rise));
    edge_det #(.FALLING(1'b0)) u_ack_r (.clk_sys, .reset_n, .d(sd.sd_ack), .pulse(ack_rise));
    edge_det #(.FALLING(1'b1)) u_ack_f (.clk_sys, .reset_n, .d(sd.sd_ack), .pulse(ack_fall));

    // Auto-load and manual load outrank both save sources; losers are dropped.
    assign trig_load = bk_ena & ((dl_done & img_present) | load_rise);
    assign trig_save = bk_ena & (save_rise | auto_rise);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        xfer_d     = xfer_q;
        lba_d      = lba_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy;
        loading_d  = loading;
        done_d     = 1'b0;
        fmt_we_d   = 1'b0;
        fmt_addr_d = fmt_addr;
        fmt_data_d = fmt_data;
        start      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig_load || trig_save) begin
                    start     = 1'b1;
                    xfer_d    = trig_load ? LOAD : SAVE;
                    lba_d     = '0;
                    busy_d    = 1'b1;
                    loading_d = trig_load;
                    rd_d      = trig_load;
                    wr_d      = ~trig_load;
                    state_d   = ACK_HI;
                end else if (fmt_rise) begin
                    fmt_we_d   = 1'b1;
                    fmt_addr_d = 2'd0;
                    fmt_data_d = hdr_word(2'd0);
                    state_d    = FMT;
                end
            end
            ACK_HI: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ACK_LO;
                end
            end
            ACK_LO: begin
                if (ack_fall) begin
                    if (lba_q == LAST_LBA) begin
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        lba_d   = lba_q + 8'd1;
                        rd_d    = (xfer_q == LOAD);
                        wr_d    = (xfer_q == SAVE);
                        state_d = ACK_HI;
                    end
                end
            end
            FMT: begin
                if (fmt_addr == LAST_FMT) begin
                    fmt_addr_d = 2'd0;
                    fmt_data_d = 16'h0000;
                    state_d    = IDLE;
                end else begin
                    fmt_we_d   = 1'b1;
                    fmt_addr_d = fmt_addr + 2'd1;
                    fmt_data_d = hdr_word(fmt_addr + 2'd1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A core write in the start cycle must survive the clear.
        if (bk_ena && !osd_open && bram_wr) pending_d = 1'b1;
        else if (start)                     pending_d = 1'b0;
        else                                pending_d = pending;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            xfer_q   <= LOAD;
            lba_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            busy     <= 1'b0;
            loading  <= 1'b0;
            pending  <= 1'b0;
            done     <= 1'b0;
            fmt_we   <= 1'b0;
            fmt_addr <= 2'd0;
            fmt_data <= 16'h0000;
        end else begin
            state_q  <= state_d;
            xfer_q   <= xfer_d;
            lba_q    <= lba_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busy     <= busy_d;
            loading  <= loading_d;
            pending  <= pending_d;
            done     <= done_d;
            fmt_we   <= fmt_we_d;
            fmt_addr <= fmt_addr_d;
            fmt_data <= fmt_data_d;
        end
    end

    assign sd.sd_lba = {24'd0, lba_q};
    assign sd.sd_rd  = rd_q;
    assign sd.sd_wr  = wr_q;

endmodule

// File: tb/tb_bram_sd_ctrl.sv
// Directed bench for bram_sd_ctrl: trigger/priority table, format table,
// and hand sequences for full transfers, lockout, pending and mid-transfer reset.
module tb_bram_sd_ctrl;

    localparam int SECTORS = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        bk_ena = 0, load_req = 0, save_req = 0, autosave_en = 0, osd_open = 0;
    logic        bram_wr = 0, dl_done = 0, img_present = 0, format_req = 0;
    logic        busy, loading, pending, fmt_we, done;
    logic [1:0]  fmt_addr;
    logic [15:0] fmt_data;

    bram_sd_ctrl_if sd_bus ();

    bram_sd_ctrl #(.SECTORS(SECTORS), .FMT_WORDS(4)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .bk_ena      (bk_ena),
        .load_req    (load_req),
        .save_req    (save_req),
        .autosave_en (autosave_en),
        .osd_open    (osd_open),
        .bram_wr     (bram_wr),
        .dl_done     (dl_done),
        .img_present (img_present),
        .format_req  (format_req),
        .sd          (sd_bus),
        .busy        (busy),
        .loading     (loading),
        .pending     (pending),
        .fmt_we      (fmt_we),
        .fmt_addr    (fmt_addr),
        .fmt_data    (fmt_data),
        .done        (done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {bk_ena, load_req, save_req, autosave_en, osd_open} = '0;
        {bram_wr, dl_done, img_present, format_req} = '0;
        sd_bus.sd_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic setup_pending();
        bk_ena  = 1'b1;
        osd_open = 1'b0;
        bram_wr = 1'b1;
        @(negedge clk_sys);
        bram_wr = 1'b0;
        check("pending_set", pending, 1);
    endtask

    // Acts as hps_io for each sector; stop_at raises the ack of that sector and returns.
    task automatic serve(input bit is_load, input int save_at, input int stop_at);
        for (int i = 0; i < SECTORS; i++) begin
            check($sformatf("req_%0d", i), is_load ? sd_bus.sd_rd : sd_bus.sd_wr, 1);
            check($sformatf("other_%0d", i), is_load ? sd_bus.sd_wr : sd_bus.sd_rd, 0);
            check($sformatf("lba_%0d", i), sd_bus.sd_lba, i);
            check($sformatf("loading_%0d", i), loading, is_load);
            check($sformatf("busy_%0d", i), busy, 1);
            sd_bus.sd_ack = 1'b1;
            if (i == save_at) save_req = 1'b1;
            if (i == stop_at) break;
            @(negedge clk_sys);
            check($sformatf("req_drop_%0d", i), sd_bus.sd_rd | sd_bus.sd_wr, 0);
            @(negedge clk_sys);
            check($sformatf("req_hold_%0d", i), sd_bus.sd_rd | sd_bus.sd_wr, 0);
            sd_bus.sd_ack = 1'b0;
            @(negedge clk_sys);
            if (i == SECTORS - 1) begin
                check("done_pulse", done, 1);
                check("busy_end", busy, 0);
                check("loading_end", loading, 0);
                check("req_end", sd_bus.sd_rd | sd_bus.sd_wr, 0);
            end else begin
                check($sformatf("done_early_%0d", i), done, 0);
            end
        end
        if (stop_at >= SECTORS) begin
            @(negedge clk_sys);
            check("done_single", done, 0);
            repeat (3) begin
                @(negedge clk_sys);
                check("no_extra_req", sd_bus.sd_rd | sd_bus.sd_wr, 0);
            end
        end
    endtask

    typedef struct {
        string name;
        bit bk, dl, img, ld, sv, as;
        bit rd, wr, ld_o;
    } vec_t;

    typedef struct {
        bit          we;
        logic [1:0]  addr;
        logic [15:0] data;
    } fmt_t;

    vec_t vecs[10];
    fmt_t fmts[4];

    initial begin
        vecs[0] = '{"autoload",      1, 1, 1, 0, 0, 0, 1, 0, 1};
        vecs[1] = '{"dl_no_img",     1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{"load",          1, 0, 0, 1, 0, 0, 1, 0, 1};
        vecs[3] = '{"save",          1, 0, 0, 0, 1, 0, 0, 1, 0};
        vecs[4] = '{"autosave",      1, 0, 0, 0, 0, 1, 0, 1, 0};
        vecs[5] = '{"load_vs_save",  1, 0, 0, 1, 1, 1, 1, 0, 1};
        vecs[6] = '{"save_vs_auto",  1, 0, 0, 0, 1, 1, 0, 1, 0};
        vecs[7] = '{"auto_vs_load",  1, 1, 1, 1, 1, 0, 1, 0, 1};
        vecs[8] = '{"gated",         0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[9] = '{"gated_dl",      0, 1, 1, 0, 0, 0, 0, 0, 0};

        fmts[0] = '{1'b1, 2'd0, 16'h5548};
        fmts[1] = '{1'b1, 2'd1, 16'h4D42};
        fmts[2] = '{1'b1, 2'd2, 16'h8800};
        fmts[3] = '{1'b1, 2'd3, 16'h8010};

        sd_bus.sd_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("rst_rd", sd_bus.sd_rd, 0);
        check("rst_wr", sd_bus.sd_wr, 0);
        check("rst_lba", sd_bus.sd_lba, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_fmt_we", fmt_we, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;

        // Trigger gating and same-cycle priority.
        foreach (vecs[k]) begin
            do_reset();
            setup_pending();
            bk_ena      = vecs[k].bk;
            dl_done     = vecs[k].dl;
            img_present = vecs[k].img;
            load_req    = vecs[k].ld;
            save_req    = vecs[k].sv;
            osd_open    = vecs[k].as;
            autosave_en = vecs[k].as;
            @(negedge clk_sys);
            dl_done = 1'b0;
            check({vecs[k].name, "_rd"}, sd_bus.sd_rd, vecs[k].rd);
            check({vecs[k].name, "_wr"}, sd_bus.sd_wr, vecs[k].wr);
            check({vecs[k].name, "_loading"}, loading, vecs[k].ld_o);
            check({vecs[k].name, "_busy"}, busy, vecs[k].rd | vecs[k].wr);
            check({vecs[k].name, "_pending"}, pending, !(vecs[k].rd | vecs[k].wr));
        end

        // Format sequence, bk_ena deliberately low.
        do_reset();
        format_req = 1'b1;
        foreach (fmts[k]) begin
            @(negedge clk_sys);
            check($sformatf("fmt_we_%0d", k), fmt_we, fmts[k].we);
            check($sformatf("fmt_addr_%0d", k), fmt_addr, fmts[k].addr);
            check($sformatf("fmt_data_%0d", k), fmt_data, fmts[k].data);
            check($sformatf("fmt_sd_%0d", k), sd_bus.sd_rd | sd_bus.sd_wr | busy, 0);
        end
        @(negedge clk_sys);
        check("fmt_we_end", fmt_we, 0);

        // Full auto-load after a download.
        do_reset();
        bk_ena = 1'b1;
        img_present = 1'b1;
        dl_done = 1'b1;
        @(negedge clk_sys);
        dl_done = 1'b0;
        serve(1'b1, -1, SECTORS);

        // Manual save wins over a simultaneous autosave; only one transfer runs.
        do_reset();
        setup_pending();
        save_req = 1'b1;
        osd_open = 1'b1;
        autosave_en = 1'b1;
        @(negedge clk_sys);
        check("save_auto_pending", pending, 0);
        serve(1'b0, -1, SECTORS);

        // Save edge during a load is ignored; the load runs to completion.
        do_reset();
        bk_ena = 1'b1;
        load_req = 1'b1;
        @(negedge clk_sys);
        serve(1'b1, 3, SECTORS);

        // Pending: set beats clear; writes with the OSD open or bk_ena low do not count.
        do_reset();
        bk_ena = 1'b1; osd_open = 1'b1; bram_wr = 1'b1;
        @(negedge clk_sys);
        check("pending_osd_open", pending, 0);
        bk_ena = 1'b0; osd_open = 1'b0;
        @(negedge clk_sys);
        check("pending_no_bk", pending, 0);
        bram_wr = 1'b0;
        setup_pending();
        load_req = 1'b1;
        bram_wr = 1'b1;
        @(negedge clk_sys);
        bram_wr = 1'b0;
        check("set_wins_rd", sd_bus.sd_rd, 1);
        check("set_wins_pending", pending, 1);
        @(negedge clk_sys);
        check("set_wins_hold", pending, 1);

        // Asynchronous reset at sector 7 with the ack held high.
        do_reset();
        bk_ena = 1'b1;
        load_req = 1'b1;
        @(negedge clk_sys);
        serve(1'b1, -1, 7);
        @(negedge clk_sys);
        check("pre_rst_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_rd", sd_bus.sd_rd | sd_bus.sd_wr, 0);
        check("mid_rst_lba", sd_bus.sd_lba, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_loading", loading, 0);
        check("mid_rst_misc", {pending, fmt_we, done}, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk_sys);
            check("held_load_no_xfer", sd_bus.sd_rd | busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_sd_ctrl.md
# bram_sd_ctrl

Sequencer for the backup-RAM save path between the core-side dual-port backup RAM and the hps_io SD sector interface. It owns the complete transfer life cycle:
- manual load/save requests, autosave on OSD open, and automatic load after a cart download;
- the per-sector `sd_rd`/`sd_wr` ↔ `sd_ack` handshake over a fixed sector count;
- the format sequence that writes the default HuBM header words.

It sits beside the backup dpram pair in `emu`. It drives port B addressing/format writes and holds the console in reset while a load is in progress.

## Interface
Parameters:
- `SECTORS`, 16: sectors per transfer (power of two, 2..256).
- `FMT_WORDS`, 4: header words written by format.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `bk_ena` in 1: save image mounted and writable; gates all transfers.
- `load_req` in 1: level; rising edge requests a load.
- `save_req` in 1: level; rising edge requests a save.
- `autosave_en` in 1: autosave option.
- `osd_open` in 1: OSD visible.
- `bram_wr` in 1: core write strobe to backup RAM.
- `dl_done` in 1: one-cycle pulse at end of cart download.
- `img_present` in 1: mounted image size is nonzero.
- `format_req` in 1: level; rising edge starts format.
- `sd_ack` in 1: hps_io sector acknowledge.
- `sd_lba` out 32: sector address.
- `sd_rd` out 1: sector read request.
- `sd_wr` out 1: sector write request.
- `busy` out 1: SD transfer active.
- `loading` out 1: load active; OR'd into core reset.
- `pending` out 1: unsaved core writes exist.
- `fmt_we` out 1: format write strobe.
- `fmt_addr` out 2: format word index.
- `fmt_data` out 16: format word.
- `done` out 1: one-cycle pulse at transfer completion.

## Operation
- Reset values: all outputs 0, state `IDLE`. Edge-detect registers reset to 1, so an input already high at reset release is not an edge.
- Triggers, all sampled only in `IDLE` and gated by `bk_ena`:
  - auto-load: `dl_done & img_present`;
  - load: rising edge of `load_req`;
  - save: rising edge of `save_req`;
  - autosave: rising edge of `pending & osd_open & autosave_en`.
- Same-cycle priority: auto-load > load > save > autosave. Losing triggers are dropped, not queued.
- Format: rising edge of `format_req`, accepted in `IDLE` only (`bk_ena` not required). Triggers of any kind arriving outside `IDLE` are ignored.
- States:
  - `IDLE`: on a trigger, set `sd_lba`=0, `busy`=1, `loading`=(load type), raise `sd_rd` for load or `sd_wr` for save, and go to `ACK_HI`.
  - `ACK_HI`: on the `sd_ack` rising edge, drop `sd_rd`/`sd_wr` and go to `ACK_LO`.
  - `ACK_LO`: on the `sd_ack` falling edge:
    - if `sd_lba`==`SECTORS-1`: clear `busy`/`loading`, pulse `done`, go to `IDLE`;
    - else: `sd_lba`+1, re-raise the same request, go to `ACK_HI`.
  - `FMT`: drive `fmt_we`=1 for `FMT_WORDS` consecutive cycles with `fmt_addr`=0..3 and `fmt_data`=header[addr], then return to `IDLE`.
- Header words: 0x5548, 0x4D42, 0x8800, 0x8010.
- `pending` set: `bk_ena & ~osd_open & bram_wr`. `pending` clear: the cycle a transfer starts. Set and clear in the same cycle → set wins.
- `bk_ena` falling mid-transfer: the transfer continues to the last sector. hps_io must see every handshake closed.
- `sd_lba[31:8]` is always 0.

## Timing
- Trigger edge at cycle N → `sd_rd`/`sd_wr` high at N+1.
- `sd_ack` high sampled at M → request low at M+1.
- `sd_ack` low sampled at K → next request, or `done`, at K+1.
- `sd_ack` already high when a request is raised: the rising edge is still required. Edge detection uses the registered previous `sd_ack`.
- Format completes in `FMT_WORDS` cycles after the edge, then `IDLE`.
- Asynchronous reset mid-transfer or mid-format: immediate return to reset values. No partial-sector recovery.

## Structure
- Package `bram_pkg`:
  - state enum (`IDLE`, `ACK_HI`, `ACK_LO`, `FMT`);
  - transfer-type enum (`LOAD`, `SAVE`);
  - header constant array `BRAM_HDR[4]`.
- One sub-module `edge_det` (rising/falling detector, reset value as parameter), instantiated for `load_req`, `save_req`, `format_req`, the autosave condition and `sd_ack`.

## Test plan
- Auto-load: `dl_done` with `bk_ena`=`img_present`=1 → 16 `sd_rd` handshakes with `sd_lba`=0..15; `loading` high throughout; single `done` one cycle after the 16th ack falls.
- Manual save during autosave: `save_req` edge and autosave condition in the same cycle → save only, exactly 16 `sd_wr` handshakes; `pending` 0 after start.
- Pending/autosave: `bram_wr` with `osd_open`=0 → `pending`=1; then `osd_open`=1, `autosave_en`=1 → save starts next cycle; `pending` cleared.
- Format: `format_req` edge → 4 consecutive `fmt_we` cycles, (addr,data) = (0,0x5548), (1,0x4D42), (2,0x8800), (3,0x8010); no SD activity.
- Gating and lockout: `bk_ena`=0 with `load_req` edge → no request. `save_req` edge during a load → ignored, load completes.
- Reset mid-transfer at sector 7, `sd_ack` held high → all outputs 0 immediately. A `load_req` held high across reset release causes no transfer.
